// File: rtl/perifericos_es_if.sv
// rtl/perifericos_es_if.sv - core-side data/address bus for the perifericos_es unit
interface perifericos_es_if;
  logic [15:0] direcciones;
  logic [15:0] datos_wr;
  logic        we;
  logic [15:0] datos_rd;
  logic        sel;

  // The core drives address, write data and strobe; it takes back read data and the hit flag.
  modport master (
    output direcciones,
    output datos_wr,
    output we,
    input  datos_rd,
    input  sel
  );

  // The peripheral decodes the address and answers with combinational read data.
  modport slave (
    input  direcciones,
    input  datos_wr,
    input  we,
    output datos_rd,
    output sel
  );
endinterface

// File: rtl/perifericos_es.sv
// rtl/perifericos_es.sv - memory-mapped I/O ports and prescaled down-counting timer
module perifericos_es #(
  parameter logic [15:0] BASE    = 16'hFF00,
  parameter int          PRESC_W = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  perifericos_es_if.slave bus,
  input  logic [15:0]     i_ent,
  output logic [15:0]     o_sal,
  output logic            o_irq,
  input  logic            i_irq_ack
);

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    EXPIRADO = 2'd2
  } estado_t;

  localparam logic [2:0] OFF_SAL    = 3'd0;
  localparam logic [2:0] OFF_ENT    = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_PRESC  = 3'd3;
  localparam logic [2:0] OFF_CARGA  = 3'd4;
  localparam logic [2:0] OFF_CUENTA = 3'd5;
  localparam logic [2:0] OFF_ESTADO = 3'd6;

  // Architectural registers
  logic [15:0]        r_sal;
  logic [15:0]        r_ent_s1;
  logic [15:0]        r_ent_s2;
  logic [2:0]         r_ctrl;      // bit0 en, bit1 autoreload, bit2 irq_en
  logic [PRESC_W-1:0] r_presc;
  logic [15:0]        r_carga;
  logic [15:0]        r_cuenta;
  logic [PRESC_W-1:0] r_pcnt;
  logic               r_flag;
  estado_t            r_state;

  // Decode and next-state wires
  logic               w_sel;
  logic [2:0]         w_off;
  logic               w_wr;
  logic               w_wr_ctrl;
  logic               w_wr_carga;
  logic               w_wr_estado;
  logic               w_running;
  logic               w_tick;
  logic               w_flag_set;
  logic               w_flag_clr;
  estado_t            w_state_nxt;
  logic [15:0]        w_cuenta_nxt;
  logic [PRESC_W-1:0] w_pcnt_nxt;

  assign w_sel       = (bus.direcciones[15:3] == BASE[15:3]);
  assign w_off       = bus.direcciones[2:0];
  assign w_wr        = bus.we & w_sel;
  assign w_wr_ctrl   = w_wr & (w_off == OFF_CTRL);
  assign w_wr_carga  = w_wr & (w_off == OFF_CARGA);
  assign w_wr_estado = w_wr & (w_off == OFF_ESTADO);

  assign w_running   = (r_state == CONTANDO);
  assign w_tick      = w_running & (r_pcnt == r_presc);

  // Acknowledge from the control unit or a 1 written to ESTADO bit0 drops the flag.
  assign w_flag_clr  = i_irq_ack | (w_wr_estado & bus.datos_wr[0]);

  assign bus.sel     = w_sel;
  assign o_sal       = r_sal;
  assign o_irq       = r_flag & r_ctrl[2];

  // Software-writable registers; read-only offsets and offset 7 drop the write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sal   <= '0;
      r_ctrl  <= '0;
      r_presc <= '0;
      r_carga <= '0;
    end else if (w_wr) begin
      case (w_off)
        OFF_SAL:   r_sal   <= bus.datos_wr;
        OFF_CTRL:  r_ctrl  <= bus.datos_wr[2:0];
        OFF_PRESC: r_presc <= bus.datos_wr[PRESC_W-1:0];
        OFF_CARGA: r_carga <= bus.datos_wr;
        default:   ;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous input pins.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ent_s1 <= '0;
      r_ent_s2 <= '0;
    end else begin
      r_ent_s1 <= i_ent;
      r_ent_s2 <= r_ent_s1;
    end
  end

  // Timer state, count, prescaler and flag registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= PARADO;
      r_cuenta <= '0;
      r_pcnt   <= '0;
      r_flag   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cuenta <= w_cuenta_nxt;
      r_pcnt   <= w_pcnt_nxt;
      if (w_flag_set) begin
        r_flag <= 1'b1;
      end else if (w_flag_clr) begin
        r_flag <= 1'b0;
      end
    end
  end

  // Timer next state: prescaled countdown, expiry handling and software overrides.
  always_comb begin
    w_state_nxt  = r_state;
    w_cuenta_nxt = r_cuenta;
    w_pcnt_nxt   = r_pcnt;
    w_flag_set   = 1'b0;

    unique case (r_state)
      PARADO, EXPIRADO: begin
        w_pcnt_nxt = '0;
        if (r_state == EXPIRADO) begin
          w_cuenta_nxt = '0;
        end
        if (w_wr_ctrl && bus.datos_wr[0]) begin
          w_state_nxt  = CONTANDO;
          w_cuenta_nxt = r_carga;
        end
      end
      CONTANDO: begin
        if (w_tick) begin
          w_pcnt_nxt = '0;
          if (r_cuenta != 16'd0) begin
            w_cuenta_nxt = r_cuenta - 16'd1;
          end else begin
            w_flag_set = 1'b1;
            if (r_ctrl[1]) begin
              w_cuenta_nxt = r_carga;
            end else begin
              w_state_nxt = EXPIRADO;
            end
          end
        end else begin
          w_pcnt_nxt = r_pcnt + 1'b1;
        end
        // A new CARGA while counting restarts the countdown from the written value.
        if (w_wr_carga) begin
          w_state_nxt  = CONTANDO;
          w_cuenta_nxt = bus.datos_wr;
          w_pcnt_nxt   = '0;
          w_flag_set   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = PARADO;
      end
    endcase

    // Disabling from any state stops the timer and freezes the current count.
    if (w_wr_ctrl && !bus.datos_wr[0]) begin
      w_state_nxt  = PARADO;
      w_cuenta_nxt = r_cuenta;
      w_pcnt_nxt   = '0;
      w_flag_set   = 1'b0;
    end
  end

  // Combinational read mux so single-cycle loads complete in the same cycle.
  always_comb begin
    bus.datos_rd = '0;
    if (w_sel) begin
      case (w_off)
        OFF_SAL:    bus.datos_rd = r_sal;
        OFF_ENT:    bus.datos_rd = r_ent_s2;
        OFF_CTRL:   bus.datos_rd = {13'd0, r_ctrl};
        OFF_PRESC:  bus.datos_rd = 16'(r_presc);
        OFF_CARGA:  bus.datos_rd = r_carga;
        OFF_CUENTA: bus.datos_rd = r_cuenta;
        OFF_ESTADO: bus.datos_rd = {14'd0, w_running, r_flag};
        default:    bus.datos_rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_perifericos_es.sv
// tb/tb_perifericos_es.sv - self-checking bench for perifericos_es
module tb_perifericos_es;

  localparam int M_STOP = 0;
  localparam int M_RUN  = 1;
  localparam int M_EXP  = 2;

  logic        clk;
  logic        rst;
  logic [15:0] ent;
  logic [15:0] sal;
  logic        irq;
  logic        ack;

  int n_chk  = 0;
  int n_fail = 0;

  perifericos_es_if bus ();

  perifericos_es #(.BASE(16'hFF00), .PRESC_W(8)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .bus       (bus),
    .i_ent     (ent),
    .o_sal     (sal),
    .o_irq     (irq),
    .i_irq_ack (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the timer is tracked as "edges elapsed since the last load".
  bit          m_valid = 1'b0;
  logic [15:0] m_sal, m_carga, m_ent1, m_ent2;
  logic [2:0]  m_ctrl;
  int          m_presc, m_base, m_el, m_mode, m_frozen;
  logic        m_flag;
  logic        t_hit, t_wr, t_stop, t_start, t_cload, t_set, t_clr;
  logic [2:0]  t_off;
  int          t_cur, t_el;

  function automatic int cur_cuenta();
    if (m_mode == M_RUN) return m_base - m_el / (m_presc + 1);
    if (m_mode == M_EXP) return 0;
    return m_frozen;
  endfunction

  function automatic logic [15:0] exp_rd();
    if (bus.direcciones[15:3] != 13'h1FE0) return 16'h0;
    case (bus.direcciones[2:0])
      3'd0:    return m_sal;
      3'd1:    return m_ent2;
      3'd2:    return {13'd0, m_ctrl};
      3'd3:    return 16'(m_presc);
      3'd4:    return m_carga;
      3'd5:    return 16'(cur_cuenta());
      3'd6:    return {14'd0, (m_mode == M_RUN), m_flag};
      default: return 16'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_sal = '0; m_carga = '0; m_ctrl = '0; m_presc = 0;
      m_ent1 = '0; m_ent2 = '0;
      m_base = 0; m_el = 0; m_mode = M_STOP; m_frozen = 0; m_flag = 1'b0;
    end else if (m_valid) begin
      t_hit   = (bus.direcciones[15:3] == 13'h1FE0);
      t_off   = bus.direcciones[2:0];
      t_wr    = bus.we && t_hit;
      t_cur   = cur_cuenta();
      t_stop  = t_wr && t_off == 3'd2 && !bus.datos_wr[0];
      t_start = t_wr && t_off == 3'd2 && bus.datos_wr[0] && m_mode != M_RUN;
      t_cload = t_wr && t_off == 3'd4 && m_mode == M_RUN;
      t_set   = 1'b0;
      m_ent2 = m_ent1;
      m_ent1 = ent;
      if (m_mode == M_RUN && !t_stop && !t_cload) begin
        t_el = m_el + 1;
        if (t_el == (m_base + 1) * (m_presc + 1)) begin
          t_set = 1'b1;
          if (m_ctrl[1]) begin
            m_base = int'(m_carga);
            m_el = 0;
          end else begin
            m_mode = M_EXP;
          end
        end else begin
          m_el = t_el;
        end
      end
      if (t_stop) begin m_frozen = t_cur; m_mode = M_STOP; end
      if (t_start) begin m_mode = M_RUN; m_base = int'(m_carga); m_el = 0; end
      if (t_cload) begin m_base = int'(bus.datos_wr); m_el = 0; end
      if (t_wr) begin
        case (t_off)
          3'd0: m_sal = bus.datos_wr;
          3'd2: m_ctrl = bus.datos_wr[2:0];
          3'd3: m_presc = int'(bus.datos_wr[7:0]);
          3'd4: m_carga = bus.datos_wr;
          default: ;
        endcase
      end
      t_clr = ack || (t_wr && t_off == 3'd6 && bus.datos_wr[0]);
      if (t_set) m_flag = 1'b1;
      else if (t_clr) m_flag = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid && !rst) begin
      chk("sel", {15'd0, bus.sel}, {15'd0, bus.direcciones[15:3] == 13'h1FE0});
      chk("datos_rd", bus.datos_rd, exp_rd());
      chk("sal", sal, m_sal);
      chk("irq", {15'd0, irq}, {15'd0, m_flag & m_ctrl[2]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.direcciones = a;
    bus.datos_wr    = d;
    bus.we          = 1'b1;
    cyc();
    bus.we          = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    bus.direcciones = a;
    #1;
  endtask

  int exp_c[8];

  initial begin
    exp_c = '{3, 3, 2, 2, 1, 1, 0, 0};
    rst = 1'b1; ack = 1'b0; ent = '0;
    bus.direcciones = '0; bus.datos_wr = '0; bus.we = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    rd(16'hFF05); chk("rst_cuenta", bus.datos_rd, 16'h0);
    chk("rst_sal", sal, 16'h0);
    chk("rst_irq", {15'd0, irq}, 16'h0);
    rd(16'hFF02); chk("rst_ctrl", bus.datos_rd, 16'h0);

    wr(16'hFF00, 16'hA5A5); #1;
    chk("sal_wr", sal, 16'hA5A5);
    chk("sal_rb", bus.datos_rd, 16'hA5A5);
    wr(16'hFE00, 16'h5A5A); rd(16'hFE00);
    chk("miss_sel", {15'd0, bus.sel}, 16'h0);
    chk("miss_rd", bus.datos_rd, 16'h0);
    chk("miss_sal", sal, 16'hA5A5);

    ent = 16'h1234; rd(16'hFF01);
    chk("ent_0", bus.datos_rd, 16'h0);
    cyc(); #1; chk("ent_1", bus.datos_rd, 16'h0);
    cyc(); #1; chk("ent_2", bus.datos_rd, 16'h1234);

    wr(16'hFF03, 16'h0001);
    wr(16'hFF04, 16'h0003);
    wr(16'hFF02, 16'h0005);
    rd(16'hFF05);
    for (int k = 0; k < 8; k++) begin
      chk("os_cuenta", bus.datos_rd, 16'(exp_c[k]));
      chk("os_irq_lo", {15'd0, irq}, 16'h0);
      cyc(); #1;
    end
    chk("os_irq_hi", {15'd0, irq}, 16'h1);
    chk("os_cuenta0", bus.datos_rd, 16'h0);
    repeat (4) cyc();
    #1; chk("os_hold", bus.datos_rd, 16'h0);
    rd(16'hFF06); chk("os_estado", bus.datos_rd, 16'h1);

    wr(16'hFF06, 16'h0001); rd(16'hFF06);
    chk("estado_clr", bus.datos_rd, 16'h0);
    wr(16'hFF02, 16'h0007); rd(16'hFF05);
    repeat (8) cyc();
    #1; chk("ar_irq1", {15'd0, irq}, 16'h1);
    chk("ar_reload", bus.datos_rd, 16'h3);
    ack = 1'b1; cyc(); ack = 1'b0; #1;
    chk("ar_ack", {15'd0, irq}, 16'h0);
    repeat (6) cyc();
    ack = 1'b1; cyc(); ack = 1'b0; #1;
    chk("ar_ack_vs_set", {15'd0, irq}, 16'h1);
    ack = 1'b1; cyc(); ack = 1'b0; #1;
    chk("ar_ack2", {15'd0, irq}, 16'h0);

    wr(16'hFF02, 16'h0000);
    wr(16'hFF02, 16'h0001);
    repeat (8) cyc();
    #1; chk("mask_irq", {15'd0, irq}, 16'h0);
    rd(16'hFF06); chk("mask_estado", bus.datos_rd, 16'h1);
    wr(16'hFF06, 16'h0001); rd(16'hFF06);
    chk("mask_clr", bus.datos_rd, 16'h0);

    wr(16'hFF02, 16'h0001);
    cyc(); cyc();
    wr(16'hFF02, 16'h0000);
    repeat (4) cyc();
    rd(16'hFF05); chk("freeze", bus.datos_rd, 16'h2);
    rd(16'hFF06); chk("freeze_run", bus.datos_rd, 16'h0);

    wr(16'hFF03, 16'h0000);
    wr(16'hFF04, 16'h0000);
    wr(16'hFF02, 16'h0005); #1;
    chk("p0_irq_lo", {15'd0, irq}, 16'h0);
    cyc(); #1;
    chk("p0_irq_hi", {15'd0, irq}, 16'h1);
    wr(16'hFF06, 16'h0001);

    wr(16'hFF03, 16'h0001);
    wr(16'hFF04, 16'h0003);
    wr(16'hFF02, 16'h0007);
    repeat (10) cyc();
    rd(16'hFF05); chk("pre_rst_cuenta", bus.datos_rd, 16'h2);
    chk("pre_rst_irq", {15'd0, irq}, 16'h1);
    rd(16'hFF06); chk("pre_rst_estado", bus.datos_rd, 16'h3);
    rst = 1'b1;
    bus.direcciones = 16'hFF00; bus.datos_wr = 16'hFFFF; bus.we = 1'b1;
    cyc();
    rst = 1'b0; bus.we = 1'b0; #1;
    chk("rst_sal_lost", sal, 16'h0);
    chk("rst_irq2", {15'd0, irq}, 16'h0);
    rd(16'hFF05); chk("rst_cuenta2", bus.datos_rd, 16'h0);
    rd(16'hFF06); chk("rst_estado2", bus.datos_rd, 16'h0);
    rd(16'hFF02); chk("rst_ctrl2", bus.datos_rd, 16'h0);
    rd(16'hFF03); chk("rst_presc2", bus.datos_rd, 16'h0);
    rd(16'hFF04); chk("rst_carga2", bus.datos_rd, 16'h0);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/perifericos_es.md
# perifericos_es

Memory-mapped I/O and timer unit on the CPU's 16-bit data/address bus, directly downstream of the single-cycle core. It decodes an 8-word window and holds an output port register and a synchronized input port. It also holds a prescaled down-counting timer with a level interrupt request and acknowledge handshake. Reads are combinational so the single-cycle core completes loads in one cycle.

## Interface
- BASE, 16'hFF00: window base address; bits [2:0] ignored.
- PRESC_W, 8: prescaler register width.
- clk  in  1  system clock, all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- direcciones  in  16  address from the core.
- datos_wr  in  16  write data from the core.
- we  in  1  write strobe: the core's output enable (oe) for the cycle.
- datos_rd  out  16  read data; 0 when not selected.
- sel  out  1  address hits the window; the core's s_datos mux uses it.
- ent  in  16  external input pins (asynchronous).
- sal  out  16  external output port register.
- irq  out  1  interrupt request, level.
- irq_ack  in  1  one-cycle acknowledge from the control unit.

## Operation
- Decode: sel = (direcciones[15:3] == BASE[15:3]). Offset = direcciones[2:0]. Writes occur only when we & sel.
- Register map:
  - 0 SAL: rw; drives sal.
  - 1 ENT: ro; two-flop synchronized ent.
  - 2 CTRL: rw; bit0 en, bit1 autoreload, bit2 irq_en; other bits read 0.
  - 3 PRESC: rw; [PRESC_W-1:0].
  - 4 CARGA: rw; reload value.
  - 5 CUENTA: ro; current count.
  - 6 ESTADO: bit0 flag, bit1 running. Writing 1 to bit0 clears flag.
  - 7: reads 0, writes ignored.
- Writes to read-only offsets are ignored.
- Prescaler: pcnt counts 0..PRESC. tick = running & (pcnt == PRESC); pcnt returns to 0 on tick. pcnt is held at 0 when not running.
- Timer FSM:
  - PARADO: entered from reset. A write to CTRL with bit0 = 1 loads cuenta <= CARGA, clears pcnt, goes to CONTANDO.
  - CONTANDO: each tick decrements cuenta while it is nonzero.
    - A tick with cuenta == 0 sets flag.
    - If autoreload = 1: cuenta <= CARGA and stay in CONTANDO.
    - If autoreload = 0: go to EXPIRADO.
  - EXPIRADO: cuenta held at 0. Re-enabling (CTRL write with bit0 = 1) behaves as from PARADO.
  - Any state: a CTRL write with bit0 = 0 goes to PARADO and keeps cuenta.
- running = (state == CONTANDO).
- Writing CARGA while CONTANDO also loads cuenta <= datos_wr and clears pcnt.
- irq = flag & irq_en. irq_ack or an ESTADO write of 1 to bit0 clears flag.
- If flag is set and cleared in the same cycle, set wins.
- Clearing irq_en masks irq without clearing flag.
- All arithmetic is unsigned 16-bit. cuenta never wraps below 0.

## Timing
- Reset values: sal = 0, CTRL = 0, PRESC = 0, CARGA = 0, cuenta = 0, pcnt = 0, flag = 0, sync flops = 0, state = PARADO. Therefore irq = 0, and datos_rd = 0 unless sel.
- datos_rd and sel are combinational from direcciones and the current registers, with zero-cycle latency.
- A write becomes visible on outputs and on read-back the cycle after the strobe edge.
- ENT read reflects ent after 2 clock edges.
- Tick period is PRESC+1 cycles.
- One-shot expiry: flag is set (CARGA+1)*(PRESC+1) cycles after the enabling write edge. irq rises on that same edge.
- Auto-reload: flag sets every (CARGA+1)*(PRESC+1) cycles.
- irq falls on the edge that samples irq_ack = 1. irq_ack is ignored when flag = 0.
- Reset asserted mid-count returns every register to its reset value on that edge. A write in the same cycle as reset is lost.

## Test plan
- Reset, then write SAL = 16'hA5A5 at 16'hFF00 -> sal = A5A5 the next cycle, read-back = A5A5. Write at 16'hFE00 -> sal unchanged, sel = 0, datos_rd = 0.
- ent = 16'h1234 -> ENT read (16'hFF01) returns 0 for 2 edges, then 1234.
- PRESC = 1, CARGA = 3, CTRL = 3'b101 -> cuenta reads 3, 2, 1, 0 every 2 cycles. flag and irq rise 8 cycles after the CTRL write. State is EXPIRADO and cuenta stays 0.
- Same setup with CTRL = 3'b111 -> irq each 8 cycles, cuenta reloads to 3. irq_ack pulse drops irq the next cycle. An ack on the same edge as a new expiry leaves irq = 1.
- flag set with irq_en = 0 -> irq = 0, ESTADO = 2'b01. Write ESTADO = 1 -> flag cleared. CTRL write with en = 0 mid-count freezes cuenta.
- reset asserted while cuenta = 2 and flag = 1 -> next cycle all registers are 0, irq = 0, and running = 0.
